// File: rtl/bin_down_ctr.sv
// Loadable N-bit binary down counter with one-cycle terminal-count pulse and optional auto-reload.
// Define BINDOWN_PRESCALE_EN to add the presc port and a PRE_W-bit tick prescaler.
module bin_down_ctr #(
  parameter int N     = 4,
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [N-1:0]     D,
  input  logic             start,
  input  logic             stop,
  input  logic             dec_en,
  input  logic             auto_reload,
`ifdef BINDOWN_PRESCALE_EN
  input  logic [PRE_W-1:0] presc,
`endif
  output logic [N-1:0]     Q,
  output logic             zero,
  output logic             tc,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [N-1:0] ONE = N'(1);

  state_t       r_state;
  logic [N-1:0] r_q;
  logic [N-1:0] r_reload;
  logic         r_tc;
  logic         r_busy;
  logic         w_tick;

`ifdef BINDOWN_PRESCALE_EN
  logic [PRE_W-1:0] r_pre;

  // Prescaler restarts whenever counting is (re)started, stopped or reloaded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pre <= '0;
    end else if (load || stop || (start && (r_state != RUN))) begin
      r_pre <= '0;
    end else if ((r_state == RUN) && dec_en) begin
      if (r_pre == presc) r_pre <= '0;
      else                r_pre <= r_pre + PRE_W'(1);
    end
  end

  assign w_tick = dec_en && (r_pre == presc);
`else
  logic [PRE_W-1:0] w_presc;

  // A divisor of zero is the undivided case: every enabled cycle ticks.
  assign w_presc = '0;
  assign w_tick  = dec_en && (w_presc == '0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_q      <= '0;
      r_reload <= '0;
      r_tc     <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_tc <= 1'b0;
      if (load) begin
        r_q      <= D;
        r_reload <= D;
        r_state  <= IDLE;
        r_busy   <= 1'b0;
      end else if (stop) begin
        if (r_state == RUN) begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              if (r_q == '0) begin
                r_state <= DONE;
                r_tc    <= 1'b1;
              end else begin
                r_state <= RUN;
                r_busy  <= 1'b1;
              end
            end
          end
          RUN: begin
            if (w_tick) begin
              if (r_q == ONE) begin
                r_tc <= 1'b1;
                if (auto_reload && (r_reload != '0)) begin
                  r_q <= r_reload;
                end else begin
                  r_q     <= '0;
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                end
              end else begin
                r_q <= r_q - ONE;
              end
            end
          end
          DONE: begin
            // Restart from the reload value; an empty reload just re-pulses tc.
            if (start) begin
              r_q <= r_reload;
              if (r_reload != '0) begin
                r_state <= RUN;
                r_busy  <= 1'b1;
              end else begin
                r_tc <= 1'b1;
              end
            end
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign Q    = r_q;
  assign zero = (r_q == '0);
  assign tc   = r_tc;
  assign busy = r_busy;

endmodule

// File: tb/tb_bin_down_ctr.sv
// Self-checking bench for bin_down_ctr: directed scenarios plus random stimulus
// compared every cycle against a behavioural model of the counter.
module tb_bin_down_ctr;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         load;
  logic [N-1:0] D;
  logic         start;
  logic         stop;
  logic         dec_en;
  logic         auto_reload;
  logic [N-1:0] Q;
  logic         zero;
  logic         tc;
  logic         busy;
`ifdef BINDOWN_PRESCALE_EN
  logic [3:0]   presc = '0;
`endif

  bin_down_ctr #(.N(N), .PRE_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .D           (D),
    .start       (start),
    .stop        (stop),
    .dec_en      (dec_en),
    .auto_reload (auto_reload),
`ifdef BINDOWN_PRESCALE_EN
    .presc       (presc),
`endif
    .Q           (Q),
    .zero        (zero),
    .tc          (tc),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: count value, reload value, running / finished flags, tc pulse.
  int mq, mrl;
  bit mrun, mdone, mtc;

  task automatic chk(input string tag, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq = 0; mrl = 0; mrun = 0; mdone = 0; mtc = 0;
  endtask

  task automatic model_step();
    mtc = 0;
    if (load) begin
      mq = int'(D); mrl = int'(D); mrun = 0; mdone = 0;
    end else if (stop) begin
      mrun = 0;
    end else if (start && !mrun) begin
      if (mdone) mq = mrl;
      if (mq == 0) begin
        mdone = 1; mtc = 1;
      end else begin
        mrun = 1; mdone = 0;
      end
    end else if (mrun && dec_en) begin
      if (mq == 1) begin
        mtc = 1;
        if (auto_reload && mrl != 0) mq = mrl;
        else begin
          mq = 0; mrun = 0; mdone = 1;
        end
      end else begin
        mq = mq - 1;
      end
    end
  endtask

  task automatic check_all();
    chk("Q", int'(Q), mq);
    chk("zero", int'(zero), int'(mq == 0));
    chk("tc", int'(tc), int'(mtc));
    chk("busy", int'(busy), int'(mrun));
  endtask

  task automatic apply(input bit l, input int d, input bit st, input bit sp,
                       input bit de, input bit ar);
    @(negedge clk);
    load = l; D = N'(d); start = st; stop = sp; dec_en = de; auto_reload = ar;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  int lat;
  bit ar_r;

  initial begin
    reset = 1'b1; load = 0; D = '0; start = 0; stop = 0; dec_en = 0; auto_reload = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b0;

    // One-shot count of 3: tc with Q=0 four cycles after the start cycle.
    apply(1, 3, 0, 0, 0, 0);
    apply(0, 0, 1, 0, 1, 0);
    lat = 1;
    while (!tc && lat < 20) begin
      apply(0, 0, 0, 0, 1, 0);
      lat++;
    end
    chk("oneshot_lat", lat, 4);
    chk("oneshot_q", int'(Q), 0);
    apply(0, 0, 0, 0, 1, 0);
    chk("oneshot_busy", int'(busy), 0);

    // Periodic reload of 2.
    apply(1, 2, 0, 0, 0, 1);
    apply(0, 0, 1, 0, 1, 1);
    repeat (8) apply(0, 0, 0, 0, 1, 1);
    chk("periodic_busy", int'(busy), 1);

    // Periodic reload of 1: tc every tick.
    apply(1, 1, 0, 0, 0, 1);
    apply(0, 0, 1, 0, 1, 1);
    repeat (4) apply(0, 0, 0, 0, 1, 1);
    chk("reload1_tc", int'(tc), 1);

    // Stop beats start; resume; load beats start.
    apply(1, 4, 0, 0, 0, 0);
    apply(0, 0, 1, 0, 0, 0);
    apply(0, 0, 1, 1, 1, 0);
    chk("stop_q", int'(Q), 4);
    chk("stop_busy", int'(busy), 0);
    apply(0, 0, 1, 0, 0, 0);
    apply(0, 0, 0, 0, 1, 0);
    chk("resume_q", int'(Q), 3);
    apply(1, 7, 1, 0, 1, 0);
    chk("load_q", int'(Q), 7);
    chk("load_busy", int'(busy), 0);

    // Zero start: immediate tc, never busy.
    apply(1, 0, 0, 0, 1, 0);
    apply(0, 0, 1, 0, 1, 0);
    chk("zero_tc", int'(tc), 1);
    chk("zero_busy", int'(busy), 0);
    apply(0, 0, 0, 0, 1, 0);
    chk("zero_tc_once", int'(tc), 0);

    // Max count 2^N-1.
    apply(1, (1 << N) - 1, 0, 0, 0, 0);
    apply(0, 0, 1, 0, 1, 0);
    lat = 1;
    while (!tc && lat < 40) begin
      apply(0, 0, 0, 0, 1, 0);
      lat++;
    end
    chk("max_lat", lat, 1 << N);

    // Asynchronous reset in the middle of a count of 5.
    apply(1, 5, 0, 0, 0, 0);
    apply(0, 0, 1, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("areset_q", int'(Q), 0);
    check_all();
    @(negedge clk);
    reset = 1'b0;

    // Random stimulus against the model.
    ar_r = 0;
    for (int i = 0; i < 3000; i++) begin
      int r_d;
      if ($urandom_range(0, 99) < 3) ar_r = ~ar_r;
      r_d = ($urandom_range(0, 9) == 0) ? $urandom_range(0, (1 << N) - 1) : $urandom_range(0, 4);
      apply($urandom_range(0, 99) < 5, r_d, $urandom_range(0, 99) < 15,
            $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 80, ar_r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
